// File: rtl/sipo_deframer_pkg.sv
// Shared definitions for the serial link: default word width and deframer FSM states.
package sipo_deframer_pkg;

  localparam int unsigned SER_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : sipo_deframer_pkg

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register; a load that arrives while the held
// word is stalled is dropped and reported with a one-cycle drop pulse.
module sipo_out_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             drop
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;

  // A consume and a load on the same edge replace the word with no bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = 1'b0;
    if (load) begin
      if (valid_q && !out_ready) begin
        drop_d = 1'b1;
      end else begin
        data_d  = load_data;
        valid_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign drop      = drop_q;

endmodule : sipo_out_reg

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: assembles shift_en-qualified bits into words,
// hands them to a valid/ready output register and flags overrun/frame errors.
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             shift_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted_c;
  logic             load_c;

  // Word with the current ser_in bit merged in; on the last bit this is the full word.
  always_comb begin
    if (MSB_FIRST) begin
      shifted_c = {shift_q[WIDTH-2:0], ser_in};
    end else begin
      shifted_c = {ser_in, shift_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    load_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (shift_en) begin
          shift_d   = shifted_c;
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          shift_d = shifted_c;
          if (bit_cnt_q == LAST_CNT) begin
            load_c    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          // Dropping shift_en mid-word discards the partial; at a word boundary it is a clean stop.
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          shift_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
    busy_d = (bit_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_data (shifted_c),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .drop      (overrun)
  );

  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule : sipo_deframer

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: fixed vector table, hand corner sequences,
// and randomized traffic against a bit-queue reference model.
module tb_sipo_deframer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_in, shift_en, out_ready;
  logic [W-1:0] out_data;
  logic         out_valid, busy, overrun, frame_err;
  logic         l_ser, l_en, l_rdy;
  logic [W-1:0] l_data;
  logic         l_valid, l_busy, l_ovr, l_ferr;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .shift_en(shift_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .ser_in(l_ser), .shift_en(l_en),
    .out_data(l_data), .out_valid(l_valid), .out_ready(l_rdy),
    .busy(l_busy), .overrun(l_ovr), .frame_err(l_ferr)
  );

  typedef struct {
    logic         ser;
    logic         en;
    logic         rdy;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         ovr;
    logic         ferr;
  } vec_t;

  vec_t vecs[$];

  // Reference model: collected bits of the current word plus the output buffer.
  bit           m_bits[$];
  logic [W-1:0] m_data;
  logic         m_valid, m_ovr, m_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] d, input logic v,
                           input logic b, input logic o, input logic f);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_busy"},  32'(busy),      32'(b));
    check({tag, "_ovr"},   32'(overrun),   32'(o));
    check({tag, "_ferr"},  32'(frame_err), 32'(f));
  endtask

  task automatic apply(input logic s, input logic e, input logic r);
    @(negedge clk);
    ser_in = s; shift_en = e; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_l(input logic s, input logic e, input logic r);
    @(negedge clk);
    l_ser = s; l_en = e; l_rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s, input logic e);
    @(negedge clk);
    rst = 1'b1; ser_in = s; shift_en = e; out_ready = 1'b0;
    l_ser = 1'b0; l_en = 1'b0; l_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; shift_en = 1'b0; ser_in = 1'b0;
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic e, input logic r);
    logic [W-1:0] word;
    bit done;
    done = 1'b0; word = '0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    if (e) begin
      m_bits.push_back(s);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word[W-1-i] = m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
    end else if (m_bits.size() != 0) begin
      m_ferr = 1'b1;
      m_bits.delete();
    end
    if (done) begin
      if (m_valid && !r) m_ovr = 1'b1;
      else begin m_data = word; m_valid = 1'b1; end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bits5, bits6;
    rst = 1'b1; ser_in = 1'b0; shift_en = 1'b0; out_ready = 1'b0;
    l_ser = 1'b0; l_en = 1'b0; l_rdy = 1'b0;

    // ser, en, rdy, data, valid, busy, ovr, ferr
    // single word 1011, valid for exactly one cycle
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0});
    // back-to-back 1011 0110
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0});
    // stalled consumer: second word dropped with overrun, then one ready cycle drains
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0});
    // abort after 2 bits, then a clean 0001
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0});

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ser, vecs[i].en, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].data, vecs[i].valid,
                vecs[i].busy, vecs[i].ovr, vecs[i].ferr);
    end

    // reset mid-word, with shift_en held high during reset, leaves no stale bits
    apply(1'b1, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1);
    do_reset(1'b1, 1'b1);
    bits5 = 4'b1100;
    for (int i = W - 1; i >= 0; i--) apply(bits5[i], 1'b1, 1'b0);
    check("rstmid_data",  32'(out_data),  32'(4'b1100));
    check("rstmid_valid", 32'(out_valid), 32'(1'b1));

    // LSB-first instance: raw bits, then a word sent LSB-first by a shifter
    do_reset(1'b0, 1'b0);
    bits6 = 4'b1101;
    apply_l(1'b1, 1'b1, 1'b1);
    apply_l(1'b0, 1'b1, 1'b1);
    apply_l(1'b1, 1'b1, 1'b1);
    apply_l(1'b1, 1'b1, 1'b1);
    check("lsb_data",  32'(l_data),  32'(bits6));
    check("lsb_valid", 32'(l_valid), 32'(1'b1));
    bits6 = 4'b1011;
    for (int i = 0; i < W; i++) apply_l(bits6[i], 1'b1, 1'b1);
    check("lsb_loop_data",  32'(l_data),  32'(4'b1011));
    check("lsb_loop_valid", 32'(l_valid), 32'(1'b1));
    apply_l(1'b0, 1'b0, 1'b1);
    check("lsb_drain_valid", 32'(l_valid), 32'(1'b0));

    // randomized traffic against the reference model
    do_reset(1'b0, 1'b0);
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic s, e, r;
      s = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 6);
      apply(s, e, r);
      model_step(s, e, r);
      check_all("rand", m_data, m_valid, 1'(m_bits.size() != 0), m_ovr, m_ferr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sipo_deframer
